// File: rtl/nibble_reg_loader_if.sv
// Control/data bundle for the nibble-serial register loader: frame control,
// readback select and the register bank view.
interface nibble_reg_loader_if #(
   parameter int NUM_REGS  = 2,
   parameter int REG_WIDTH = 32,
   parameter int NIB_W     = 4,
   parameter int SEL_W     = 1
);
   localparam int IDX_W = $clog2(REG_WIDTH / NIB_W);

   logic                          start;
   logic [SEL_W-1:0]              start_sel;
   logic                          nib_valid;
   logic [NIB_W-1:0]              nib_in;
   logic                          abort;
   logic                          clr;
   logic [SEL_W-1:0]              rd_sel;
   logic [IDX_W-1:0]              rd_idx;
   logic [NUM_REGS*REG_WIDTH-1:0] regs;
   logic [NUM_REGS-1:0]           reg_valid;
   logic                          busy;
   logic                          done;
   logic                          err;
   logic [NIB_W-1:0]              rd_nib;

   modport master (
      output start, start_sel, nib_valid, nib_in, abort, clr, rd_sel, rd_idx,
      input  regs, reg_valid, busy, done, err, rd_nib
   );

   modport slave (
      input  start, start_sel, nib_valid, nib_in, abort, clr, rd_sel, rd_idx,
      output regs, reg_valid, busy, done, err, rd_nib
   );
endinterface

// File: rtl/nibble_reg_loader.sv
// Loads one of NUM_REGS registers MSB-nibble first through a shadow buffer;
// the target only changes on a complete frame, one cycle after the last nibble.
module nibble_reg_loader #(
   parameter int NUM_REGS  = 2,
   parameter int REG_WIDTH = 32,
   parameter int NIB_W     = 4,
   parameter int SEL_W     = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   nibble_reg_loader_if.slave  bus
);
   localparam int NNIB  = REG_WIDTH / NIB_W;
   localparam int CNT_W = $clog2(NNIB);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t                             state;
   logic [SEL_W-1:0]                   sel;
   logic [CNT_W-1:0]                   count;
   logic [REG_WIDTH-1:0]               shadow;
   logic [NUM_REGS-1:0][REG_WIDTH-1:0] bank;
   logic [NUM_REGS-1:0]                valid;
   logic                               busy_q, done_q, err_q;
   logic                               start_ok;

   assign start_ok = (int'(bus.start_sel) < NUM_REGS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sel    <= '0;
         count  <= '0;
         shadow <= '0;
         bank   <= '0;
         valid  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               // clr outranks start on the same select; bad selects only flag err
               if (bus.clr && start_ok) begin
                  bank[bus.start_sel]  <= '0;
                  valid[bus.start_sel] <= 1'b0;
               end else if ((bus.clr || bus.start) && !start_ok) begin
                  err_q <= 1'b1;
               end else if (bus.start) begin
                  sel    <= bus.start_sel;
                  count  <= '0;
                  shadow <= '0;
                  busy_q <= 1'b1;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               if (bus.start || bus.clr) err_q <= 1'b1;
               if (bus.abort) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else if (bus.nib_valid) begin
                  shadow <= {shadow[REG_WIDTH-NIB_W-1:0], bus.nib_in};
                  count  <= count + 1'b1;
                  if (count == CNT_W'(NNIB - 1)) state <= COMMIT;
               end
            end
            COMMIT: begin
               bank[sel]  <= shadow;
               valid[sel] <= 1'b1;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Readback sees committed registers only; the shadow is never visible.
   always_comb begin
      bus.rd_nib = '0;
      if (int'(bus.rd_sel) < NUM_REGS)
         bus.rd_nib = bank[bus.rd_sel][bus.rd_idx*NIB_W +: NIB_W];
   end

   assign bus.regs      = bank;
   assign bus.reg_valid = valid;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_nibble_reg_loader.sv
// Scoreboarded bench: default 2x32 loader plus a 3-register variant for bad selects.
module tb_nibble_reg_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nibble_reg_loader_if #(.NUM_REGS(2), .REG_WIDTH(32), .NIB_W(4), .SEL_W(1)) a_if ();
   nibble_reg_loader_if #(.NUM_REGS(3), .REG_WIDTH(32), .NIB_W(4), .SEL_W(2)) b_if ();

   nibble_reg_loader #(.NUM_REGS(2), .REG_WIDTH(32), .NIB_W(4), .SEL_W(1))
      u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   nibble_reg_loader #(.NUM_REGS(3), .REG_WIDTH(32), .NIB_W(4), .SEL_W(2))
      u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

   typedef struct packed {
      logic        sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Every done on the default instance must match the oldest expected commit.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && a_if.done) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_done got done=1 want no commit pending");
         end else begin
            e = sb.pop_front();
            if (a_if.regs[e.sel*32 +: 32] !== e.val || a_if.reg_valid[e.sel] !== 1'b1) begin
               bad++;
               $display("FAIL sb_commit sel=%0d got=%h valid=%b want=%h valid=1",
                        e.sel, a_if.regs[e.sel*32 +: 32], a_if.reg_valid[e.sel], e.val);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_if.start = 0; a_if.start_sel = '0; a_if.nib_valid = 0; a_if.nib_in = '0;
      a_if.abort = 0; a_if.clr = 0; a_if.rd_sel = '0; a_if.rd_idx = '0;
      b_if.start = 0; b_if.start_sel = '0; b_if.nib_valid = 0; b_if.nib_in = '0;
      b_if.abort = 0; b_if.clr = 0; b_if.rd_sel = '0; b_if.rd_idx = '0;
   endtask

   task automatic nib(input logic [3:0] n);
      a_if.nib_valid = 1; a_if.nib_in = n;
      step();
      a_if.nib_valid = 0;
   endtask

   task automatic begin_frame(input logic sel);
      a_if.start_sel = sel; a_if.start = 1;
      step();
      a_if.start = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) step();
      total++; if (a_if.regs !== 64'h0) begin bad++; $display("FAIL reset_regs got=%h want=0", a_if.regs); end
      total++; if (a_if.reg_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", a_if.reg_valid); end
      total++; if ({a_if.busy, a_if.done, a_if.err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {a_if.busy, a_if.done, a_if.err}); end
      total++; if (a_if.rd_nib !== 4'h0) begin bad++; $display("FAIL reset_rdnib got=%h want=0", a_if.rd_nib); end
      rst_n = 1;
      step();
   endtask

   task automatic test_load_consecutive();
      logic [3:0] n;
      begin_frame(1'b0);
      total++; if (a_if.busy !== 1'b1) begin bad++; $display("FAIL l0_busy_start got=%b want=1", a_if.busy); end
      sb.push_back('{sel: 1'b0, val: 32'h12345678});
      for (int i = 1; i <= 8; i++) begin
         n = 4'(i);
         nib(n);
      end
      total++; if (a_if.done !== 1'b0 || a_if.busy !== 1'b1) begin bad++; $display("FAIL l0_commit_cycle got done=%b busy=%b want done=0 busy=1", a_if.done, a_if.busy); end
      total++; if (a_if.regs[31:0] !== 32'h0) begin bad++; $display("FAIL l0_early_update got=%h want=0", a_if.regs[31:0]); end
      step();
      total++; if (a_if.regs[31:0] !== 32'h12345678) begin bad++; $display("FAIL l0_value got=%h want=12345678", a_if.regs[31:0]); end
      total++; if (a_if.reg_valid !== 2'b01 || a_if.regs[63:32] !== 32'h0) begin bad++; $display("FAIL l0_others got valid=%b r1=%h want valid=01 r1=0", a_if.reg_valid, a_if.regs[63:32]); end
      total++; if (a_if.done !== 1'b1 || a_if.busy !== 1'b0) begin bad++; $display("FAIL l0_done got done=%b busy=%b want done=1 busy=0", a_if.done, a_if.busy); end
      step();
      total++; if (a_if.done !== 1'b0) begin bad++; $display("FAIL l0_done_pulse got=%b want=0", a_if.done); end
   endtask

   task automatic test_load_gaps();
      logic [31:0] v = 32'hABCDEF01;
      begin_frame(1'b1);
      sb.push_back('{sel: 1'b1, val: v});
      for (int i = 0; i < 8; i++) begin
         nib(v[31-4*i -: 4]);
         if (i != 7) step();
      end
      total++; if (a_if.regs[63:32] !== 32'h0 || a_if.busy !== 1'b1) begin bad++; $display("FAIL l1_pre_commit got r1=%h busy=%b want r1=0 busy=1", a_if.regs[63:32], a_if.busy); end
      step();
      total++; if (a_if.regs[63:32] !== v) begin bad++; $display("FAIL l1_value got=%h want=%h", a_if.regs[63:32], v); end
      total++; if (a_if.regs[31:0] !== 32'h12345678 || a_if.reg_valid !== 2'b11) begin bad++; $display("FAIL l1_others got r0=%h valid=%b want r0=12345678 valid=11", a_if.regs[31:0], a_if.reg_valid); end
      a_if.rd_sel = 1; a_if.rd_idx = 7; #1;
      total++; if (a_if.rd_nib !== 4'hA) begin bad++; $display("FAIL rd_r1_i7 got=%h want=a", a_if.rd_nib); end
      a_if.rd_idx = 0; #1;
      total++; if (a_if.rd_nib !== 4'h1) begin bad++; $display("FAIL rd_r1_i0 got=%h want=1", a_if.rd_nib); end
      a_if.rd_sel = 0; a_if.rd_idx = 6; #1;
      total++; if (a_if.rd_nib !== 4'h2) begin bad++; $display("FAIL rd_r0_i6 got=%h want=2", a_if.rd_nib); end
      step();
   endtask

   task automatic test_abort();
      begin_frame(1'b0);
      repeat (5) nib(4'hF);
      a_if.rd_sel = 0; a_if.rd_idx = 0; #1;
      total++; if (a_if.rd_nib !== 4'h8) begin bad++; $display("FAIL abort_rd_shadow got=%h want=8", a_if.rd_nib); end
      a_if.abort = 1; a_if.nib_valid = 1; a_if.nib_in = 4'hE;
      step();
      a_if.abort = 0; a_if.nib_valid = 0;
      total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", a_if.busy); end
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (a_if.done !== 1'b0 || a_if.regs[31:0] !== 32'h12345678) begin bad++; $display("FAIL abort_hold got done=%b r0=%h want done=0 r0=12345678", a_if.done, a_if.regs[31:0]); end
      end
   endtask

   task automatic test_back_to_back();
      begin_frame(1'b0);
      sb.push_back('{sel: 1'b0, val: 32'h98765432});
      nib(4'h9); nib(4'h8); nib(4'h7);
      a_if.start = 1; a_if.start_sel = 1;
      nib(4'h6);
      a_if.start = 0;
      total++; if (a_if.err !== 1'b1 || a_if.busy !== 1'b1) begin bad++; $display("FAIL start_in_load got err=%b busy=%b want err=1 busy=1", a_if.err, a_if.busy); end
      nib(4'h5);
      total++; if (a_if.err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b want=0", a_if.err); end
      a_if.clr = 1;
      nib(4'h4);
      a_if.clr = 0;
      total++; if (a_if.err !== 1'b1) begin bad++; $display("FAIL clr_in_load got err=%b want=1", a_if.err); end
      nib(4'h3); nib(4'h2);
      step();
      total++; if (a_if.regs !== {32'hABCDEF01, 32'h98765432} || a_if.reg_valid !== 2'b11) begin bad++; $display("FAIL overwrite got regs=%h valid=%b want abcdef0198765432 valid=11", a_if.regs, a_if.reg_valid); end
      step();
   endtask

   task automatic test_clr_start();
      a_if.clr = 1; a_if.start = 1; a_if.start_sel = 1;
      step();
      a_if.clr = 0; a_if.start = 0;
      total++; if (a_if.regs !== {32'h0, 32'h98765432} || a_if.reg_valid !== 2'b01) begin bad++; $display("FAIL clr_reg1 got regs=%h valid=%b want 0000000098765432 valid=01", a_if.regs, a_if.reg_valid); end
      total++; if (a_if.busy !== 1'b0 || a_if.err !== 1'b0) begin bad++; $display("FAIL clr_no_frame got busy=%b err=%b want 0 0", a_if.busy, a_if.err); end
      nib(4'h5); nib(4'h5);
      total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL clr_idle_nibs got busy=%b want=0", a_if.busy); end
   endtask

   task automatic test_bad_sel();
      logic [31:0] v = 32'h13579BDF;
      b_if.start = 1; b_if.start_sel = 3;
      step();
      b_if.start = 0;
      total++; if (b_if.err !== 1'b1 || b_if.busy !== 1'b0) begin bad++; $display("FAIL badsel_start got err=%b busy=%b want err=1 busy=0", b_if.err, b_if.busy); end
      step();
      total++; if (b_if.err !== 1'b0 || b_if.busy !== 1'b0) begin bad++; $display("FAIL badsel_after got err=%b busy=%b want 0 0", b_if.err, b_if.busy); end
      b_if.start = 1; b_if.start_sel = 2;
      step();
      b_if.start = 0;
      for (int i = 0; i < 8; i++) begin
         b_if.nib_valid = 1; b_if.nib_in = v[31-4*i -: 4];
         step();
      end
      b_if.nib_valid = 0;
      step();
      total++; if (b_if.done !== 1'b1 || b_if.regs !== {v, 64'h0} || b_if.reg_valid !== 3'b100) begin bad++; $display("FAIL b_load2 got done=%b regs=%h valid=%b want done=1 regs=%h valid=100", b_if.done, b_if.regs, b_if.reg_valid, {v, 64'h0}); end
      b_if.clr = 1; b_if.start_sel = 3;
      step();
      b_if.clr = 0;
      total++; if (b_if.err !== 1'b1 || b_if.regs !== {v, 64'h0}) begin bad++; $display("FAIL badsel_clr got err=%b regs=%h want err=1 unchanged", b_if.err, b_if.regs); end
      b_if.rd_sel = 2; b_if.rd_idx = 7; #1;
      total++; if (b_if.rd_nib !== 4'h1) begin bad++; $display("FAIL b_rd_r2 got=%h want=1", b_if.rd_nib); end
      b_if.rd_sel = 3; #1;
      total++; if (b_if.rd_nib !== 4'h0) begin bad++; $display("FAIL b_rd_oob got=%h want=0", b_if.rd_nib); end
      step();
   endtask

   task automatic test_async_reset();
      begin_frame(1'b1);
      repeat (4) nib(4'h7);
      #3 rst_n = 0;
      #1;
      total++; if (a_if.regs !== 64'h0 || a_if.reg_valid !== 2'b00 || b_if.regs !== 96'h0) begin bad++; $display("FAIL arst_regs got a=%h av=%b b=%h want all 0", a_if.regs, a_if.reg_valid, b_if.regs); end
      total++; if ({a_if.busy, a_if.done, a_if.err} !== 3'b000) begin bad++; $display("FAIL arst_flags got=%b want=000", {a_if.busy, a_if.done, a_if.err}); end
      a_if.rd_sel = 0; a_if.rd_idx = 0; #1;
      total++; if (a_if.rd_nib !== 4'h0) begin bad++; $display("FAIL arst_rdnib got=%h want=0", a_if.rd_nib); end
      rst_n = 1;
      for (int i = 0; i < 10; i++) nib(4'(i));
      step();
      total++; if (a_if.busy !== 1'b0 || a_if.regs !== 64'h0 || a_if.reg_valid !== 2'b00) begin bad++; $display("FAIL arst_ignored got busy=%b regs=%h valid=%b want 0", a_if.busy, a_if.regs, a_if.reg_valid); end
   endtask

   initial begin
      test_reset();
      test_load_consecutive();
      test_load_gaps();
      test_abort();
      test_back_to_back();
      test_clr_start();
      test_bad_sel();
      test_async_reset();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got pending=%0d want=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
